// File: rtl/binary_to_ascii_serializer.sv
// binary_to_ascii_serializer: double-dabble binary-to-BCD converter streaming ASCII digits MSD first
module binary_to_ascii_serializer #(
  parameter int DIGITS_LENGTH = 8,
  parameter int BIN_WIDTH = DIGITS_LENGTH*4,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] bin_data_in,
  input  logic                 bin_valid_in,
  output logic                 bin_ready_out,
  output logic [7:0]           ascii_char_out,
  output logic                 ascii_valid_out,
  input  logic                 ascii_ready_in,
  output logic                 ascii_last_out,
  output logic                 overflow_out,
  output logic                 busy_out
);
  localparam int BCD_W = 4*DIGITS_LENGTH;
  localparam int IW = (DIGITS_LENGTH > 1) ? $clog2(DIGITS_LENGTH) : 1;
  localparam int CW = $clog2(BIN_WIDTH+1);
  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, EMIT = 2'd2} state_t;
  state_t               state_q;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, adj;
  logic                 carry;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q, idx_dec, top_idx;
  logic [7:0]           char_q;
  logic                 valid_q, last_q, ovf_q;
  function automatic logic [7:0] ascii(input logic [BCD_W-1:0] b, input logic [IW-1:0] i);
    return {4'h3, b[{i, 2'b00} +: 4]};
  endfunction
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS_LENGTH; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end
  // bit leaving the top nibble is the 10**DIGITS_LENGTH carry: dropped from the result, kept as overflow
  assign {carry, bcd_d, shift_d} = {adj, shift_q, 1'b0};
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < DIGITS_LENGTH; i++)
      if (!SUPPRESS_ZEROS || bcd_d[4*i +: 4] != 4'd0) top_idx = IW'(i);
  end
  assign idx_dec = idx_q - 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bin_valid_in) begin
          state_q <= CONVERT;
          shift_q <= bin_data_in;
          bcd_q   <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
        CONVERT: begin
          shift_q <= shift_d;
          bcd_q   <= bcd_d;
          ovf_q   <= ovf_q | carry;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_WIDTH-1)) begin
            state_q <= EMIT;
            idx_q   <= top_idx;
            char_q  <= ascii(bcd_d, top_idx);
            last_q  <= (top_idx == '0);
            valid_q <= 1'b1;
          end
        end
        EMIT: if (ascii_ready_in) begin
          if (last_q) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            char_q  <= 8'h00;
            ovf_q   <= 1'b0;
          end else begin
            idx_q  <= idx_dec;
            char_q <= ascii(bcd_q, idx_dec);
            last_q <= (idx_dec == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bin_ready_out   = (state_q == IDLE);
  assign busy_out        = (state_q != IDLE);
  assign ascii_char_out  = char_q;
  assign ascii_valid_out = valid_q;
  assign ascii_last_out  = last_q;
  assign overflow_out    = ovf_q;
endmodule
